// File: rtl/game_state_ctrl.sv
// rtl/game_state_ctrl.sv - game flow controller committing screen changes on vblank rising edges
package vga_pkg;
  typedef enum logic [1:0] {
    START    = 2'd0,
    GAME     = 2'd1,
    PLAYER_1 = 2'd2,
    PLAYER_2 = 2'd3
  } state;
endpackage

module game_state_ctrl
  import vga_pkg::*;
#(
  parameter int WIN_HOLD_FRAMES = 300,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start_btn,
  input  logic p1_win,
  input  logic p2_win,
  input  logic vblnk,
  output state screen,
  output logic game_rst,
  output logic screen_chg
);

  localparam int CW = $clog2(WIN_HOLD_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIN_HOLD_FRAMES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   btn_q, btn_d;
  logic                   vblnk_q, vblnk_d;
  logic                   pending_q, pending_d;
  state                   target_q, target_d;
  logic                   p1_lat_q, p1_lat_d;
  logic                   p2_lat_q, p2_lat_d;
  logic [CW-1:0]          frame_cnt_q, frame_cnt_d;
  state                   screen_q, screen_d;
  logic                   game_rst_q, game_rst_d;
  logic                   screen_chg_q, screen_chg_d;

  logic start_evt;
  logic vblnk_rise;
  logic commit;
  logic p1_any;
  logic p2_any;
  logic on_win_screen;

  assign start_evt     = sync_q[SYNC_STAGES-1] & ~btn_q;
  assign vblnk_rise    = vblnk & ~vblnk_q;
  assign commit        = vblnk_rise & pending_q;
  assign p1_any        = p1_lat_q | p1_win;
  assign p2_any        = p2_lat_q | p2_win;
  assign on_win_screen = (screen_q == PLAYER_1) || (screen_q == PLAYER_2);

  // Next-state: button sync, request capture, frame-boundary commit, hold counter
  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], start_btn};
    btn_d        = sync_q[SYNC_STAGES-1];
    vblnk_d      = vblnk;
    pending_d    = pending_q;
    target_d     = target_q;
    p1_lat_d     = p1_lat_q;
    p2_lat_d     = p2_lat_q;
    frame_cnt_d  = frame_cnt_q;
    screen_d     = screen_q;
    game_rst_d   = 1'b0;
    screen_chg_d = 1'b0;

    // Win flags are only meaningful while a game is running.
    if (screen_q == GAME) begin
      p1_lat_d = p1_any;
      p2_lat_d = p2_any;
    end

    if (commit) begin
      // The pending request was raised on an earlier cycle; apply it now.
      screen_d     = target_q;
      pending_d    = 1'b0;
      screen_chg_d = 1'b1;
      game_rst_d   = (target_q == GAME);
      frame_cnt_d  = '0;
      if (target_q != GAME) begin
        p1_lat_d = 1'b0;
        p2_lat_d = 1'b0;
      end
    end else begin
      if (vblnk_rise && on_win_screen && (frame_cnt_q != CNT_MAX)) begin
        frame_cnt_d = frame_cnt_q + CW'(1);
      end
      // Only one request may be outstanding; later events are dropped.
      if (!pending_q) begin
        unique case (screen_q)
          START: begin
            if (start_evt) begin
              pending_d = 1'b1;
              target_d  = GAME;
            end
          end
          GAME: begin
            if (p1_any || p2_any) begin
              pending_d = 1'b1;
              target_d  = p1_any ? PLAYER_1 : PLAYER_2;
            end
          end
          PLAYER_1, PLAYER_2: begin
            if (start_evt || (vblnk_rise && (frame_cnt_q == CNT_MAX))) begin
              pending_d = 1'b1;
              target_d  = START;
            end
          end
          default: screen_d = START;
        endcase
      end
    end
  end

  // State register with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q       <= '0;
      btn_q        <= 1'b0;
      vblnk_q      <= 1'b0;
      pending_q    <= 1'b0;
      target_q     <= START;
      p1_lat_q     <= 1'b0;
      p2_lat_q     <= 1'b0;
      frame_cnt_q  <= '0;
      screen_q     <= START;
      game_rst_q   <= 1'b0;
      screen_chg_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      btn_q        <= btn_d;
      vblnk_q      <= vblnk_d;
      pending_q    <= pending_d;
      target_q     <= target_d;
      p1_lat_q     <= p1_lat_d;
      p2_lat_q     <= p2_lat_d;
      frame_cnt_q  <= frame_cnt_d;
      screen_q     <= screen_d;
      game_rst_q   <= game_rst_d;
      screen_chg_q <= screen_chg_d;
    end
  end

  assign screen     = screen_q;
  assign game_rst   = game_rst_q;
  assign screen_chg = screen_chg_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// tb/tb_game_state_ctrl.sv - self-checking bench for game_state_ctrl
module tb_game_state_ctrl;
  import vga_pkg::*;

  typedef struct {
    logic btn;
    logic p1;
    logic p2;
    logic vb;
    state scr;
    logic grst;
    logic chg;
  } vec_t;

  typedef struct {
    state scr;
    logic grst;
    logic chg;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_btn = 1'b0;
  logic p1_win = 1'b0;
  logic p2_win = 1'b0;
  logic vblnk = 1'b0;
  state screen;
  logic game_rst;
  logic screen_chg;

  int n_total = 0;
  int n_pass  = 0;

  vec_t vecs[$];
  exp_t exp_q[$];

  game_state_ctrl #(
    .WIN_HOLD_FRAMES(3),
    .SYNC_STAGES    (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_btn (start_btn),
    .p1_win    (p1_win),
    .p2_win    (p2_win),
    .vblnk     (vblnk),
    .screen    (screen),
    .game_rst  (game_rst),
    .screen_chg(screen_chg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_out(input string tag, input int id, input state es, input logic eg, input logic ec);
    n_total++;
    if (screen === es) n_pass++;
    else $display("FAIL %s[%0d] screen: got %0d want %0d", tag, id, screen, es);
    n_total++;
    if (game_rst === eg) n_pass++;
    else $display("FAIL %s[%0d] game_rst: got %b want %b", tag, id, game_rst, eg);
    n_total++;
    if (screen_chg === ec) n_pass++;
    else $display("FAIL %s[%0d] screen_chg: got %b want %b", tag, id, screen_chg, ec);
  endtask

  task automatic add(input logic b, input logic a1, input logic a2, input logic v,
                     input state s, input logic g, input logic c);
    vec_t r;
    r.btn = b; r.p1 = a1; r.p2 = a2; r.vb = v; r.scr = s; r.grst = g; r.chg = c;
    vecs.push_back(r);
  endtask

  task automatic tick(input vec_t v, input string tag, input int id);
    exp_t e;
    e.scr = v.scr; e.grst = v.grst; e.chg = v.chg;
    exp_q.push_back(e);
    start_btn = v.btn;
    p1_win    = v.p1;
    p2_win    = v.p2;
    vblnk     = v.vb;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_out(tag, id, e.scr, e.grst, e.chg);
  endtask

  task automatic step(input logic b, input logic a1, input logic a2, input logic v,
                      input state s, input logic g, input logic c, input string tag, input int id);
    vec_t r;
    r.btn = b; r.p1 = a1; r.p2 = a2; r.vb = v; r.scr = s; r.grst = g; r.chg = c;
    tick(r, tag, id);
  endtask

  task automatic async_reset(input string tag);
    #2;
    start_btn = 1'b0;
    rst = 1'b1;
    #1;
    check_out(tag, 0, START, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // btn p1 p2 vb | screen grst chg
    add(0, 0, 0, 0, START,    0, 0);
    add(0, 0, 0, 1, START,    0, 0);
    add(0, 0, 0, 0, START,    0, 0);
    add(1, 0, 0, 0, START,    0, 0);
    add(1, 0, 0, 0, START,    0, 0);
    add(1, 0, 0, 0, START,    0, 0);
    add(1, 0, 0, 1, GAME,     1, 1);
    add(1, 0, 0, 0, GAME,     0, 0);
    add(1, 0, 0, 1, GAME,     0, 0);
    add(0, 0, 0, 0, GAME,     0, 0);
    add(0, 1, 1, 0, GAME,     0, 0);
    add(0, 0, 0, 0, GAME,     0, 0);
    add(0, 0, 0, 1, PLAYER_1, 0, 1);
    add(0, 0, 0, 0, PLAYER_1, 0, 0);
    add(0, 0, 0, 1, PLAYER_1, 0, 0);
    add(1, 0, 0, 0, PLAYER_1, 0, 0);
    add(1, 0, 0, 0, PLAYER_1, 0, 0);
    add(1, 0, 0, 0, PLAYER_1, 0, 0);
    add(0, 0, 0, 1, START,    0, 1);
    add(0, 0, 1, 0, START,    0, 0);
    add(0, 0, 0, 1, START,    0, 0);
    add(0, 0, 0, 0, START,    0, 0);

    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 0, START, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i], "vec", i);
    end

    // start_evt in the same cycle as a vblank rise waits for the next rise
    step(1, 0, 0, 0, START, 0, 0, "same_cyc", 0);
    step(1, 0, 0, 0, START, 0, 0, "same_cyc", 1);
    step(1, 0, 0, 1, START, 0, 0, "same_cyc", 2);
    step(1, 0, 0, 0, START, 0, 0, "same_cyc", 3);
    step(0, 0, 0, 1, GAME,  1, 1, "same_cyc", 4);
    step(0, 0, 0, 0, GAME,  0, 0, "same_cyc", 5);

    // p2 win, then hold timeout of 3 frames returns to START on the 4th rise
    step(0, 0, 1, 0, GAME,     0, 0, "hold", 0);
    step(0, 0, 0, 1, PLAYER_2, 0, 1, "hold", 1);
    step(0, 1, 0, 0, PLAYER_2, 0, 0, "hold", 2);
    for (int f = 1; f <= 3; f++) begin
      step(0, 0, 0, 1, PLAYER_2, 0, 0, "hold", 2 * f + 1);
      step(0, 0, 0, 0, PLAYER_2, 0, 0, "hold", 2 * f + 2);
    end
    step(0, 0, 0, 1, START, 0, 1, "hold", 9);
    step(0, 0, 0, 0, START, 0, 0, "hold", 10);

    // asynchronous reset from GAME takes effect without a clock edge
    step(1, 0, 0, 0, START, 0, 0, "rst_game", 0);
    step(1, 0, 0, 0, START, 0, 0, "rst_game", 1);
    step(1, 0, 0, 0, START, 0, 0, "rst_game", 2);
    step(0, 0, 0, 1, GAME,  1, 1, "rst_game", 3);
    step(0, 0, 0, 0, GAME,  0, 0, "rst_game", 4);
    async_reset("rst_game_async");

    // a pending request does not survive reset
    step(1, 0, 0, 0, START, 0, 0, "rst_pend", 0);
    step(1, 0, 0, 0, START, 0, 0, "rst_pend", 1);
    step(1, 0, 0, 0, START, 0, 0, "rst_pend", 2);
    async_reset("rst_pend_async");
    step(0, 0, 0, 0, START, 0, 0, "rst_pend", 3);
    step(0, 0, 0, 1, START, 0, 0, "rst_pend", 4);
    step(0, 0, 0, 0, START, 0, 0, "rst_pend", 5);
    step(0, 0, 0, 1, START, 0, 0, "rst_pend", 6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
